alu_word_sequencer: RTL

- Upstream/downstream wrapper stage around the combinational 128-bit ALU.
- Accepts a command plus two DWIDTH-bit operands as a stream of WWIDTH-bit words over a valid/ready handshake, holds them in registers and drives the ALU from those registers.
- After one execute cycle, captures the ALU result and the c/z/o/s flags.
- Returns the result as WWIDTH-bit words over a second valid/ready handshake.

---
 rtl/alu_word_sequencer_if.sv | 26 ++
 rtl/alu_word_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer_if.sv
// Word-stream bundle for alu_word_sequencer: operand words in, result words out.
// master is the producer/consumer side of the streams; slave is the sequencer.
interface alu_word_sequencer_if #(
    parameter int WWIDTH = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WWIDTH-1:0] in_data;
    logic [2:0]        in_opsel;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [WWIDTH-1:0] out_data;
    logic              out_last;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_data, in_opsel, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_opsel, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last, out_flags
    );
endinterface

// File: rtl/alu_word_sequencer.sv
// Serialises operands into registers that drive a combinational ALU, executes for one
// cycle, then streams the captured result back out word by word with its flags.
module alu_word_sequencer #(
    parameter int DWIDTH = 128,
    parameter int WWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_word_sequencer_if.slave bus,
    output logic [DWIDTH-1:0]   alu_op1,
    output logic [DWIDTH-1:0]   alu_op2,
    output logic [2:0]          alu_opsel,
    output logic                alu_mode,
    input  logic [DWIDTH-1:0]   alu_result,
    input  logic                alu_c_flag,
    input  logic                alu_z_flag,
    input  logic                alu_o_flag,
    input  logic                alu_s_flag,
    output logic                busy
);
    localparam int NW = DWIDTH / WWIDTH;
    localparam int CW = $clog2(2 * NW);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_IN  = CW'(2 * NW - 1);
    localparam logic [IW-1:0] LAST_OUT = IW'(NW - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_EXEC,
        ST_UNLOAD
    } state_e;

    state_e            state_q,     state_d;
    logic [CW-1:0]     in_cnt_q,    in_cnt_d;
    logic [IW-1:0]     out_idx_q,   out_idx_d;
    logic [DWIDTH-1:0] op1_q,       op1_d;
    logic [DWIDTH-1:0] op2_q,       op2_d;
    logic [DWIDTH-1:0] result_q,    result_d;
    logic [2:0]        opsel_q,     opsel_d;
    logic              mode_q,      mode_d;
    logic [3:0]        flags_q,     flags_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic [WWIDTH-1:0] out_data_q,  out_data_d;
    logic              busy_q,      busy_d;

    logic in_accept;
    logic out_accept;

    assign in_accept  = bus.in_valid && in_ready_q;
    assign out_accept = out_valid_q && bus.out_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_idx_d   = out_idx_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        result_d    = result_q;
        opsel_d     = opsel_q;
        mode_d      = mode_q;
        flags_d     = flags_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_LOAD: begin
                if (in_accept) begin
                    if (in_cnt_q == '0) begin
                        opsel_d = bus.in_opsel;
                        mode_d  = bus.in_mode;
                    end
                    for (int k = 0; k < NW; k++) begin
                        if (in_cnt_q == CW'(k)) begin
                            op1_d[k*WWIDTH +: WWIDTH] = bus.in_data;
                        end
                        if (in_cnt_q == CW'(k + NW)) begin
                            op2_d[k*WWIDTH +: WWIDTH] = bus.in_data;
                        end
                    end
                    if (in_cnt_q == LAST_IN) begin
                        in_cnt_d = '0;
                        state_d  = ST_EXEC;
                    end else begin
                        in_cnt_d = in_cnt_q + CW'(1);
                    end
                end
            end

            ST_EXEC: begin
                result_d   = alu_result;
                flags_d    = {alu_c_flag, alu_z_flag, alu_o_flag, alu_s_flag};
                out_idx_d  = '0;
                out_data_d = alu_result[WWIDTH-1:0];
                out_last_d = (NW == 1);
                state_d    = ST_UNLOAD;
            end

            ST_UNLOAD: begin
                if (out_accept) begin
                    if (out_idx_q == LAST_OUT) begin
                        out_idx_d  = '0;
                        out_last_d = 1'b0;
                        out_data_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        out_idx_d  = out_idx_q + IW'(1);
                        out_last_d = (out_idx_d == LAST_OUT);
                        for (int k = 0; k < NW; k++) begin
                            if (out_idx_d == IW'(k)) begin
                                out_data_d = result_q[k*WWIDTH +: WWIDTH];
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Handshake and status outputs are registered from the next state.
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_UNLOAD);
        busy_d      = !((state_d == ST_LOAD) && (in_cnt_d == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide result register is cleared too, so nothing stale can leak after an abort.
            state_q     <= ST_LOAD;
            in_cnt_q    <= '0;
            out_idx_q   <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            opsel_q     <= '0;
            mode_q      <= 1'b0;
            flags_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_idx_q   <= out_idx_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            result_q    <= result_d;
            opsel_q     <= opsel_d;
            mode_q      <= mode_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_flags = flags_q;
    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign alu_opsel     = opsel_q;
    assign alu_mode      = mode_q;
    assign busy          = busy_q;
endmodule
